// File: rtl/harq_send_reader.sv
// Reader end of the combine/HARQ ping-pong handshake: walks the selected buffer
// 0..L, absorbs the 1-cycle SRAM latency and streams entries through a 2-deep skid FIFO.
module harq_send_reader #(
  parameter int DATA_WIDTH = 160,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_SENDHARQ_Data_request,
  input  logic                  i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]           i_SENDHARQ_Data_ncb,
  output logic [ADDR_WIDTH-1:0] o_SENDHARQ_Data_Address,
  input  logic [DATA_WIDTH-1:0] i_Ping_Read_Data,
  input  logic [DATA_WIDTH-1:0] i_Pong_Read_Data,
  output logic [DATA_WIDTH-1:0] o_HARQ_Data,
  output logic                  o_HARQ_Valid,
  input  logic                  i_HARQ_Ready,
  output logic                  o_HARQ_Last,
  output logic                  o_SENDHARQ_Data_Comp,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_READ     = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  localparam logic [11:0] L_MAX = 12'((2 ** ADDR_WIDTH) - 1);

  logic [1:0]            state;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] last_addr_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   pop_cnt;
  logic                  inflight;
  logic [1:0]            fifo_cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic [11:0]           ncb_words;
  logic [2:0]            occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  unused_ncb_lsbs;

  assign ncb_words       = i_SENDHARQ_Data_ncb[15:4];
  assign unused_ncb_lsbs = ^i_SENDHARQ_Data_ncb[3:0];

  always_comb begin
    last_addr_d = ADDR_WIDTH'(ncb_words);
    if (ncb_words > L_MAX) last_addr_d = ADDR_WIDTH'(L_MAX);
  end

  assign o_HARQ_Valid = (fifo_cnt != 2'd0);
  assign pop          = o_HARQ_Valid && i_HARQ_Ready;
  assign push         = inflight;

  // A pop in this cycle frees a slot that the next read can already claim.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_READ) && (occupancy < 3'd2);

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state     <= ST_IDLE;
      sel       <= 1'b0;
      last_addr <= '0;
      addr      <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      fifo_cnt  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      inflight <= issue;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          addr <= '0;
          if (i_SENDHARQ_Data_request) begin
            state     <= ST_READ;
            sel       <= i_SENDHARQ_Data_PingPong_Indicator;
            last_addr <= last_addr_d;
            pop_cnt   <= '0;
          end
        end
        ST_READ: begin
          // The address parks on L after the final issue so it only wraps via IDLE.
          if (issue) begin
            if (addr == last_addr) state <= ST_DRAIN;
            else                   addr  <= addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop && (pop_cnt == {1'b0, last_addr})) state <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          addr  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (push) fifo_mem[wr_ptr] <= sel ? i_Pong_Read_Data : i_Ping_Read_Data;
  end

  assign o_HARQ_Data             = o_HARQ_Valid ? fifo_mem[rd_ptr] : '0;
  assign o_HARQ_Last             = o_HARQ_Valid && (pop_cnt == {1'b0, last_addr});
  assign o_SENDHARQ_Data_Comp    = (state == ST_COMPLETE);
  assign o_busy                  = (state != ST_IDLE);
  assign o_SENDHARQ_Data_Address = addr;

endmodule

// File: tb/tb_harq_send_reader.sv
// Randomized bench for harq_send_reader: expected stream is buffer[sel][0..L] with
// L = min(ncb/16, 2047), plus cycle timing, backpressure and reset scenarios.
module tb_harq_send_reader;
  localparam int DW = 160;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req;
  logic          ind;
  logic [15:0]   ncb_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] ping_q, pong_q;
  logic [DW-1:0] data;
  logic          valid, ready, last, comp, busy;

  logic [DW-1:0] ping_mem [2048];
  logic [DW-1:0] pong_mem [2048];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  harq_send_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_core_clk                        (clk),
    .i_rx_rstn                         (rstn),
    .i_SENDHARQ_Data_request           (req),
    .i_SENDHARQ_Data_PingPong_Indicator(ind),
    .i_SENDHARQ_Data_ncb               (ncb_in),
    .o_SENDHARQ_Data_Address           (addr),
    .i_Ping_Read_Data                  (ping_q),
    .i_Pong_Read_Data                  (pong_q),
    .o_HARQ_Data                       (data),
    .o_HARQ_Valid                      (valid),
    .i_HARQ_Ready                      (ready),
    .o_HARQ_Last                       (last),
    .o_SENDHARQ_Data_Comp              (comp),
    .o_busy                            (busy)
  );

  // Synchronous-read SRAM models: q reflects the address of the previous cycle.
  always @(posedge clk) begin
    ping_q <= ping_mem[addr];
    pong_q <= pong_mem[addr];
  end

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode: 0 = ready held high (exact timing checked), 1 = 1,0,0,1 pattern, 2 = random.
  task automatic run_transfer(input logic sel, input logic [15:0] ncb, input int mode,
                              input bit disturb, input bit chain, input bit pre,
                              input logic nsel, input logic [15:0] nncb);
    int L, cyc, idx, comps, comp_cyc, budget;
    logic pv, pr;
    logic [DW-1:0] pd, expd;
    logic exp_last, exp_valid;
    L = int'(ncb[15:4]);
    if (L > 2047) L = 2047;
    if (!pre) begin
      @(posedge clk); #1;
      req = 1'b1; ind = sel; ncb_in = ncb;
      ready = ready_for(mode, 0);
      @(negedge clk);
    end
    cyc = 0; idx = 0; comps = 0; comp_cyc = -1; budget = 4 * L + 40;
    pv = 1'b0; pr = 1'b0; pd = '0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      req = 1'b0;
      if (disturb && cyc == 5) begin
        ind = ~sel; ncb_in = ~ncb; req = 1'b1;
      end
      if (chain && cyc == L + 4) req = 1'b1;
      if (chain && cyc == L + 5) begin
        req = 1'b1; ind = nsel; ncb_in = nncb;
      end
      ready = ready_for(mode, cyc);
      @(negedge clk);

      if (busy) begin
        checks++;
        if (int'(addr) > L) begin
          errors++; $display("FAIL addr_range cyc=%0d addr=%0d max=%0d", cyc, addr, L);
        end
      end
      exp_last = valid && (idx == L);
      checks++;
      if (last !== exp_last) begin
        errors++; $display("FAIL last cyc=%0d got=%b exp=%b", cyc, last, exp_last);
      end
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || data !== pd) begin
          errors++; $display("FAIL stall_hold cyc=%0d valid=%b data=%h exp=%h", cyc, valid, data, pd);
        end
      end
      if (mode == 0) begin
        exp_valid = (cyc >= 3) && (cyc <= L + 3);
        checks++;
        if (valid !== exp_valid) begin
          errors++; $display("FAIL valid_timing cyc=%0d got=%b exp=%b", cyc, valid, exp_valid);
        end
        if (cyc <= L + 1) begin
          checks++;
          if (int'(addr) != cyc - 1) begin
            errors++; $display("FAIL addr_seq cyc=%0d got=%0d exp=%0d", cyc, addr, cyc - 1);
          end
        end else if (busy && L > 0) begin
          checks++;
          if (addr === '0) begin
            errors++; $display("FAIL addr_wrap_busy cyc=%0d got=0 exp=nonzero", cyc);
          end
        end
      end
      if (valid && ready) begin
        checks++;
        if (idx > L) begin
          errors++; $display("FAIL extra_entry cyc=%0d idx=%0d max=%0d", cyc, idx, L);
        end else begin
          expd = sel ? pong_mem[idx] : ping_mem[idx];
          if (data !== expd) begin
            errors++; $display("FAIL data idx=%0d got=%h exp=%h", idx, data, expd);
          end
        end
        idx++;
      end
      pv = valid; pr = ready; pd = data;
      if (comp) begin
        comps++;
        if (comp_cyc < 0) comp_cyc = cyc;
      end
      if (comp_cyc >= 0 && cyc == comp_cyc + 1) begin
        checks++;
        if (busy !== 1'b0 || addr !== '0) begin
          errors++; $display("FAIL idle_after_comp cyc=%0d busy=%b addr=%0d exp busy=0 addr=0", cyc, busy, addr);
        end
      end
      if (chain && cyc == L + 5) break;
      if (comp_cyc >= 0 && cyc == comp_cyc + 2) break;
      if (cyc >= budget) begin
        errors++; checks++;
        $display("FAIL timeout L=%0d popped=%0d comps=%0d", L, idx, comps);
        break;
      end
    end
    checks++;
    if (idx != L + 1) begin
      errors++; $display("FAIL entry_count got=%0d exp=%0d", idx, L + 1);
    end
    checks++;
    if (comps != 1) begin
      errors++; $display("FAIL comp_count got=%0d exp=1", comps);
    end
    if (mode == 0) begin
      checks++;
      if (comp_cyc != L + 4) begin
        errors++; $display("FAIL comp_timing got=%0d exp=%0d", comp_cyc, L + 4);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (valid !== 1'b0 || last !== 1'b0 || comp !== 1'b0 || busy !== 1'b0 ||
        addr !== '0 || data !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b last=%b comp=%b busy=%b addr=%0d exp all 0",
               valid, last, comp, busy, addr);
    end
  endtask

  task automatic test_basic;
    run_transfer(1'b0, 16'd144, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_pong_disturb;
    run_transfer(1'b1, 16'd133, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_backpressure;
    run_transfer(1'b0, 16'd80, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_transfer(1'b1, 16'd200, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_boundary;
    run_transfer(1'b0, 16'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_transfer(1'b1, 16'd15, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_transfer(1'b0, 16'($urandom_range(0, 15)), 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_transfer(1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back;
    run_transfer(1'b0, 16'd32, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd64);
    run_transfer(1'b1, 16'd64, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++)
      run_transfer(1'($urandom_range(0, 1)), 16'($urandom_range(0, 640)), 2,
                   1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset_mid;
    int seen_comp;
    @(posedge clk); #1;
    req = 1'b1; ind = 1'b0; ncb_in = 16'd144; ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
    // Cycle 7 presents entry 4; pull reset asynchronously mid-cycle.
    #2 rstn = 1'b0;
    #1 test_reset;
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    seen_comp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (comp) seen_comp++;
    end
    checks++;
    if (seen_comp != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle comps=%0d busy=%b exp 0 and 0", seen_comp, busy);
    end
    run_transfer(1'b1, 16'd48, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++)
      for (int w = 0; w < 5; w++) begin
        ping_mem[i][w*32 +: 32] = $urandom;
        pong_mem[i][w*32 +: 32] = $urandom;
      end
    req = 1'b0; ind = 1'b0; ncb_in = '0; ready = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2 test_reset;
    @(posedge clk); #1 rstn = 1'b1;
    test_basic;
    test_pong_disturb;
    test_backpressure;
    test_boundary;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
